axis_cic_interpolator: RTL



---
 rtl/cic_pkg.sv | 36 +++
 rtl/cic_stage.sv | 68 ++++++
 rtl/axis_cic_interpolator.sv | 118 +++++++++++
 3 files changed

// File: rtl/cic_pkg.sv
// -----------------------------------------------------------------------------
// cic_pkg
// Shared definitions for the AXI-Stream CIC interpolator:
//   - cic_width_f   : full-precision word width (input + growth + guard bit)
//   - phase_width_f : width of the interpolation phase counter for ratio R
//   - cic_word_t    : signed full-precision word at the default configuration
//   - PHASE_W       : phase counter width at the default ratio
//   - stage_mode_t  : selects comb or integrator behaviour in cic_stage
// -----------------------------------------------------------------------------
package cic_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_GROWTH = 7;
    localparam int DEF_SIGN   = 1;
    localparam int DEF_R      = 100;

    function automatic int cic_width_f(input int width, input int growth, input int sign);
        return width + growth + sign;
    endfunction

    // A counter for R >= 2 phases needs at least one bit.
    function automatic int phase_width_f(input int r);
        return (r > 2) ? $clog2(r) : 1;
    endfunction

    localparam int CIC_WIDTH = cic_width_f(DEF_WIDTH, DEF_GROWTH, DEF_SIGN);
    localparam int PHASE_W   = phase_width_f(DEF_R);

    typedef logic signed [CIC_WIDTH-1:0] cic_word_t;

    typedef enum logic [0:0] {
        STAGE_COMB  = 1'b0,
        STAGE_INTEG = 1'b1
    } stage_mode_t;

endpackage

// File: rtl/cic_stage.sv
// -----------------------------------------------------------------------------
// cic_stage
// One CIC section stage, behaviour chosen by MODE:
//   STAGE_COMB  : o_data = i_data - i_data delayed by M enabled cycles
//                 (combinational output, M-deep delay line advances on i_en)
//   STAGE_INTEG : o_data = accumulator register; acc <= acc + i_data on i_en
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset, clears all state
//   i_en   in   advance enable
//   i_data in   CW-bit stage input
//   o_data out  CW-bit stage output
// All arithmetic wraps modulo 2^CW.
// -----------------------------------------------------------------------------
module cic_stage
    import cic_pkg::*;
#(
    parameter stage_mode_t MODE = STAGE_INTEG,
    parameter int          CW   = 24,
    parameter int          M    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic [CW-1:0] i_data,
    output logic [CW-1:0] o_data
);

    if (MODE == STAGE_COMB) begin : g_comb
        logic [CW-1:0] r_dly [0:M-1];

        // Delay line holding the last M accepted stage inputs.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < M; i++) begin
                    r_dly[i] <= {CW{1'b0}};
                end
            end else if (i_en) begin
                r_dly[0] <= i_data;
                for (int i = 1; i < M; i++) begin
                    r_dly[i] <= r_dly[i-1];
                end
            end else begin
                for (int i = 0; i < M; i++) begin
                    r_dly[i] <= r_dly[i];
                end
            end
        end

        assign o_data = i_data - r_dly[M-1];
    end else begin : g_integ
        logic [CW-1:0] r_acc;

        // Wrapping accumulator.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_acc <= {CW{1'b0}};
            end else if (i_en) begin
                r_acc <= r_acc + i_data;
            end else begin
                r_acc <= r_acc;
            end
        end

        assign o_data = r_acc;
    end

endmodule

// File: rtl/axis_cic_interpolator.sv
// -----------------------------------------------------------------------------
// axis_cic_interpolator
// AXI-Stream CIC interpolator: upsamples WIDTH-bit signed samples by R and
// emits full-precision CIC_WIDTH-bit samples (feeds the ZOH stage directly).
// Ports:
//   aclk                in   clock
//   arst                in   asynchronous active-high reset
//   s_axis_data_tdata   in   WIDTH-bit signed input sample
//   s_axis_data_tvalid  in   input valid
//   s_axis_data_tready  out  input ready (only at phase 0 with output space)
//   m_axis_data_tdata   out  CIC_WIDTH-bit output sample (last integrator)
//   m_axis_data_tvalid  out  output valid
//   m_axis_data_tready  in   output ready
// A "step" advances phase and integrators; combs advance only on the step
// that accepts an input (phase 0).
// -----------------------------------------------------------------------------
module axis_cic_interpolator
    import cic_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int N         = 1,
    parameter int M         = 1,
    parameter int R         = 100,
    parameter int GROWTH    = 7,
    parameter int SIGN      = 1,
    parameter int CIC_WIDTH = cic_width_f(WIDTH, GROWTH, SIGN)
) (
    input  logic                 aclk,
    input  logic                 arst,
    input  logic [WIDTH-1:0]     s_axis_data_tdata,
    input  logic                 s_axis_data_tvalid,
    output logic                 s_axis_data_tready,
    output logic [CIC_WIDTH-1:0] m_axis_data_tdata,
    output logic                 m_axis_data_tvalid,
    input  logic                 m_axis_data_tready
);

    localparam int             PW         = phase_width_f(R);
    localparam logic [PW-1:0]  PHASE_LAST = PW'(R - 1);

    logic [PW-1:0]        r_phase;
    logic                 r_m_tvalid;
    logic                 w_out_free;
    logic                 w_phase_zero;
    logic                 w_step;
    logic                 w_accept;
    logic [CIC_WIDTH-1:0] w_comb  [0:N];
    logic [CIC_WIDTH-1:0] w_integ [0:N];

    // Output register can take a new value when empty or being drained.
    assign w_out_free   = ~r_m_tvalid | m_axis_data_tready;
    assign w_phase_zero = (r_phase == {PW{1'b0}});
    // Phase 0 needs a fresh input; the other R-1 phases run on zeros.
    assign w_step       = w_out_free & (~w_phase_zero | s_axis_data_tvalid);
    assign w_accept     = w_step & w_phase_zero;

    assign s_axis_data_tready = w_phase_zero & w_out_free & ~arst;
    assign m_axis_data_tvalid = r_m_tvalid;

    // Phase counter 0..R-1, advancing on every step.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            r_phase <= {PW{1'b0}};
        end else if (w_step) begin
            r_phase <= (r_phase == PHASE_LAST) ? {PW{1'b0}} : r_phase + PW'(1);
        end else begin
            r_phase <= r_phase;
        end
    end

    // Output valid: set by a step, cleared when a beat leaves without a step.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            r_m_tvalid <= 1'b0;
        end else if (w_step) begin
            r_m_tvalid <= 1'b1;
        end else if (r_m_tvalid & m_axis_data_tready) begin
            r_m_tvalid <= 1'b0;
        end else begin
            r_m_tvalid <= r_m_tvalid;
        end
    end

    assign w_comb[0] = {{(CIC_WIDTH-WIDTH){s_axis_data_tdata[WIDTH-1]}}, s_axis_data_tdata};

    // Zero-stuffing upsampler between comb and integrator sections.
    assign w_integ[0] = w_phase_zero ? w_comb[N] : {CIC_WIDTH{1'b0}};

    for (genvar k = 1; k <= N; k++) begin : g_stages
        cic_stage #(
            .MODE (STAGE_COMB),
            .CW   (CIC_WIDTH),
            .M    (M)
        ) u_comb (
            .clk    (aclk),
            .rst    (arst),
            .i_en   (w_accept),
            .i_data (w_comb[k-1]),
            .o_data (w_comb[k])
        );

        // Each integrator sums the previous stage's registered (old) value.
        cic_stage #(
            .MODE (STAGE_INTEG),
            .CW   (CIC_WIDTH),
            .M    (M)
        ) u_integ (
            .clk    (aclk),
            .rst    (arst),
            .i_en   (w_step),
            .i_data (w_integ[k-1]),
            .o_data (w_integ[k])
        );
    end

    assign m_axis_data_tdata = w_integ[N];

endmodule
